apb_master_arbiter: RTL and testbench



---
 rtl/apb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/apb_master_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master arbiter.
// States: IDLE = arbitrate | SETUP = psel only | ACCESS = psel+penable, wait pready/timeout
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;
    localparam int APB_PROT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from the slot after the last grant.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last_grant,
    output logic [N-1:0]     o_grant,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_valid = 1'b0;
        w_idx   = i_last_grant;
        for (int i = 1; i <= N; i++) begin
            w_idx = IDX_W'((int'(i_last_grant) + i) % N);
            if (!o_valid && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_valid        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Multi-requester APB master: round-robin arbitration, one transfer at a time,
// with an optional ACCESS-phase timeout that forces an error completion.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int dataWidth = APB_DATA_W,
    parameter int addrWidth = APB_ADDR_W,
    parameter int NREQ      = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ*addrWidth-1:0]       reqAddr,
    input  logic [NREQ-1:0]                 reqWrite,
    input  logic [NREQ*dataWidth-1:0]       reqWdata,
    input  logic [NREQ*(dataWidth/8)-1:0]   reqStrb,
    input  logic [NREQ*APB_PROT_W-1:0]      reqProt,
    output logic [NREQ-1:0]                 done,
    output logic [dataWidth-1:0]            rdata,
    output logic                            slverr,
    output logic                            busy,
    output logic                            pselx,
    output logic                            penable,
    output logic                            pwrite,
    output logic [addrWidth-1:0]            paddr,
    output logic [dataWidth-1:0]            pwdata,
    output logic [dataWidth/8-1:0]          pstrb,
    output logic [APB_PROT_W-1:0]           pprot,
    input  logic                            pready,
    input  logic                            pslverr,
    input  logic [dataWidth-1:0]            prdata
);

    localparam int STRB_W  = dataWidth / 8;
    localparam int IDX_W   = $clog2(NREQ);
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    apb_state_e              r_state, w_state_nxt;
    logic                    r_psel, w_psel_nxt;
    logic                    r_penable, w_penable_nxt;
    logic                    r_pwrite;
    logic [addrWidth-1:0]    r_paddr;
    logic [dataWidth-1:0]    r_pwdata;
    logic [STRB_W-1:0]       r_pstrb;
    logic [APB_PROT_W-1:0]   r_pprot;
    logic [NREQ-1:0]         r_done, w_done_nxt;
    logic [dataWidth-1:0]    r_rdata, w_rdata_nxt;
    logic                    r_slverr, w_slverr_nxt;
    logic [IDX_W-1:0]        r_last, w_last_nxt;
    logic [IDX_W-1:0]        r_win;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic                    w_latch;
    logic                    w_timeout;

    logic [NREQ-1:0]         w_req_masked;
    logic [NREQ-1:0]         w_grant;
    logic                    w_arb_valid;
    logic [IDX_W-1:0]        w_win_idx;
    logic [addrWidth-1:0]    w_sel_addr;
    logic                    w_sel_write;
    logic [dataWidth-1:0]    w_sel_wdata;
    logic [STRB_W-1:0]       w_sel_strb;
    logic [APB_PROT_W-1:0]   w_sel_prot;

    // A requester still seeing its done pulse has not yet had a chance to drop req.
    assign w_req_masked = req & ~r_done;

    rr_arbiter #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req        (w_req_masked),
        .i_last_grant (r_last),
        .o_grant      (w_grant),
        .o_valid      (w_arb_valid)
    );

    always_comb begin
        w_win_idx   = '0;
        w_sel_addr  = '0;
        w_sel_write = 1'b0;
        w_sel_wdata = '0;
        w_sel_strb  = '0;
        w_sel_prot  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_win_idx   = IDX_W'(i);
                w_sel_addr  = reqAddr[i*addrWidth +: addrWidth];
                w_sel_write = reqWrite[i];
                w_sel_wdata = reqWdata[i*dataWidth +: dataWidth];
                w_sel_strb  = reqStrb[i*STRB_W +: STRB_W];
                w_sel_prot  = reqProt[i*APB_PROT_W +: APB_PROT_W];
            end
        end
    end

    assign w_timeout = (TIMEOUT > 0) && (r_cnt == CNT_W'(TO_LAST));

    always_comb begin
        w_state_nxt   = r_state;
        w_psel_nxt    = r_psel;
        w_penable_nxt = r_penable;
        w_done_nxt    = '0;
        w_rdata_nxt   = r_rdata;
        w_slverr_nxt  = r_slverr;
        w_last_nxt    = r_last;
        w_cnt_nxt     = r_cnt;
        w_latch       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = ST_SETUP;
                    w_psel_nxt  = 1'b1;
                    w_latch     = 1'b1;
                end
            end
            ST_SETUP: begin
                w_state_nxt   = ST_ACCESS;
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
            end
            ST_ACCESS: begin
                if (pready || w_timeout) begin
                    w_state_nxt       = ST_IDLE;
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_done_nxt[r_win] = 1'b1;
                    w_last_nxt        = r_win;
                    w_cnt_nxt         = '0;
                    // pready on the final timeout cycle still counts as a normal completion
                    if (pready) begin
                        w_rdata_nxt  = r_pwrite ? '0 : prdata;
                        w_slverr_nxt = pslverr;
                    end else begin
                        w_rdata_nxt  = '0;
                        w_slverr_nxt = 1'b1;
                    end
                end else if (TIMEOUT > 0) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_psel_nxt    = 1'b0;
                w_penable_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_pprot   <= '0;
            r_done    <= '0;
            r_rdata   <= '0;
            r_slverr  <= 1'b0;
            r_last    <= IDX_W'(NREQ - 1);
            r_win     <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
            r_done    <= w_done_nxt;
            r_rdata   <= w_rdata_nxt;
            r_slverr  <= w_slverr_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            if (w_latch) begin
                r_win    <= w_win_idx;
                r_paddr  <= w_sel_addr;
                r_pwrite <= w_sel_write;
                r_pwdata <= w_sel_wdata;
                r_pstrb  <= w_sel_strb;
                r_pprot  <= w_sel_prot;
            end
        end
    end

    assign done    = r_done;
    assign rdata   = r_rdata;
    assign slverr  = r_slverr;
    assign busy    = (r_state != ST_IDLE);
    assign pselx   = r_psel;
    assign penable = r_penable;
    assign pwrite  = r_pwrite;
    assign paddr   = r_paddr;
    assign pwdata  = r_pwdata;
    assign pstrb   = r_pstrb;
    assign pprot   = r_pprot;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: expected completions queued at request time.
module tb_apb_master_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int N  = 2;
    localparam int TO = 16;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N*AW-1:0]   reqAddr = '0;
    logic [N-1:0]      reqWrite = '0;
    logic [N*DW-1:0]   reqWdata = '0;
    logic [N*SW-1:0]   reqStrb = '0;
    logic [N*3-1:0]    reqProt = '0;
    logic [N-1:0]      done;
    logic [DW-1:0]     rdata;
    logic              slverr, busy, pselx, penable, pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [SW-1:0]     pstrb;
    logic [2:0]        pprot;
    logic              pready = 1'b0;
    logic              pslverr = 1'b0;
    logic [DW-1:0]     prdata = '0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        slverr;
    } exp_t;
    exp_t sb[$];

    apb_master_arbiter #(
        .dataWidth (DW),
        .addrWidth (AW),
        .NREQ      (N),
        .TIMEOUT   (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .reqAddr  (reqAddr),
        .reqWrite (reqWrite),
        .reqWdata (reqWdata),
        .reqStrb  (reqStrb),
        .reqProt  (reqProt),
        .done     (done),
        .rdata    (rdata),
        .slverr   (slverr),
        .busy     (busy),
        .pselx    (pselx),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .pprot    (pprot),
        .pready   (pready),
        .pslverr  (pslverr),
        .prdata   (prdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_req(input int i, input logic [31:0] a, input logic w,
                             input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        reqAddr[i*AW +: AW]  = a;
        reqWrite[i]          = w;
        reqWdata[i*DW +: DW] = d;
        reqStrb[i*SW +: SW]  = s;
        reqProt[i*3 +: 3]    = p;
    endtask

    task automatic wait_done(input int budget, output logic [N-1:0] d, output int n);
        d = '0;
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (done !== '0) begin
                d = done;
                break;
            end
        end
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok = (sb.size() != 0);
        if (ok) e = sb.pop_front();
        else begin
            e.idx = -1; e.rdata = '0; e.slverr = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({pselx, penable, pwrite, busy, slverr} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: psel/pen/pwrite/busy/slverr=%b want 00000", {pselx, penable, pwrite, busy, slverr});
        end
        checks++;
        if (done !== '0) begin
            errors++;
            $display("FAIL reset_done: got %b want 00", done);
        end
        checks++;
        if ({paddr, pwdata, pstrb, pprot} !== '0) begin
            errors++;
            $display("FAIL reset_cmd: paddr=%h pwdata=%h pstrb=%h pprot=%h want all 0", paddr, pwdata, pstrb, pprot);
        end
        checks++;
        if (rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 0", rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        exp_t e;
        bit   ok;
        pready = 1'b1; pslverr = 1'b0; prdata = 32'hDEADBEEF;
        drive_req(0, 32'h10, 1'b0, 32'h0, 4'h0, 3'b001);
        req[0] = 1'b1;
        sb.push_back('{0, 32'hDEADBEEF, 1'b0});
        @(negedge clk);
        checks++;
        if ({pselx, penable, pwrite, busy, paddr} !== {1'b1, 1'b0, 1'b0, 1'b1, 32'h10}) begin
            errors++;
            $display("FAIL read_setup: psel=%b pen=%b pwrite=%b busy=%b paddr=%h want 1 0 0 1 00000010", pselx, penable, pwrite, busy, paddr);
        end
        @(negedge clk);
        checks++;
        if ({pselx, penable} !== 2'b11) begin
            errors++;
            $display("FAIL read_access: psel/pen=%b want 11", {pselx, penable});
        end
        @(negedge clk);
        pop_exp(e, ok);
        checks++;
        if (!ok || done !== N'(1 << e.idx) || rdata !== e.rdata || slverr !== e.slverr) begin
            errors++;
            $display("FAIL read_done: done=%b rdata=%h slverr=%b want done idx %0d rdata=%h slverr=%b", done, rdata, slverr, e.idx, e.rdata, e.slverr);
        end
        // req stays high through the done cycle; masking must prevent a re-grant
        @(negedge clk);
        checks++;
        if ({done, busy, pselx} !== 4'b0000) begin
            errors++;
            $display("FAIL read_mask: done=%b busy=%b psel=%b want 00 0 0", done, busy, pselx);
        end
        req[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_slverr();
        exp_t e;
        bit   ok;
        logic [N-1:0] d;
        int   n;
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFEF00D;
        drive_req(0, 32'h30, 1'b0, 32'h0, 4'h0, 3'b000);
        req[0] = 1'b1;
        sb.push_back('{0, 32'hCAFEF00D, 1'b1});
        wait_done(10, d, n);
        req[0] = 1'b0;
        pop_exp(e, ok);
        checks++;
        if (!ok || d !== N'(1 << e.idx) || n != 3 || rdata !== e.rdata || slverr !== e.slverr) begin
            errors++;
            $display("FAIL slverr_done: done=%b cycles=%0d rdata=%h slverr=%b want idx %0d cycles 3 rdata=%h slverr=%b", d, n, rdata, slverr, e.idx, e.rdata, e.slverr);
        end
        pslverr = 1'b0; prdata = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (rdata !== e.rdata || slverr !== e.slverr) begin
            errors++;
            $display("FAIL slverr_hold: rdata=%h slverr=%b want %h %b", rdata, slverr, e.rdata, e.slverr);
        end
    endtask

    task automatic test_contention();
        exp_t e;
        bit   ok;
        logic [N-1:0] d;
        int   n;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pready = 1'b1; pslverr = 1'b0;
        drive_req(0, 32'h100, 1'b0, 32'h0, 4'h0, 3'b000);
        drive_req(1, 32'h200, 1'b0, 32'h0, 4'h0, 3'b000);
        for (int round = 0; round < 2; round++) begin
            prdata = 32'hA000_0000 + 32'(round);
            req = 2'b11;
            sb.push_back('{0, 32'hA000_0000 + 32'(round), 1'b0});
            sb.push_back('{1, 32'hB000_0000 + 32'(round), 1'b0});
            wait_done(10, d, n);
            req[0] = 1'b0;
            prdata = 32'hB000_0000 + 32'(round);
            pop_exp(e, ok);
            checks++;
            if (!ok || d !== N'(1 << e.idx) || rdata !== e.rdata) begin
                errors++;
                $display("FAIL contention_first r%0d: done=%b rdata=%h want idx %0d rdata=%h", round, d, rdata, e.idx, e.rdata);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL contention_gap r%0d: busy=%b want 0 in done cycle", round, busy);
            end
            wait_done(10, d, n);
            req[1] = 1'b0;
            pop_exp(e, ok);
            checks++;
            if (!ok || d !== N'(1 << e.idx) || n != 3 || rdata !== e.rdata) begin
                errors++;
                $display("FAIL contention_second r%0d: done=%b cycles=%0d rdata=%h want idx %0d cycles 3 rdata=%h", round, d, n, rdata, e.idx, e.rdata);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wait_states();
        exp_t e;
        bit   ok;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h7777_7777;
        drive_req(0, 32'h20, 1'b1, 32'h12345678, 4'hF, 3'b010);
        req[0] = 1'b1;
        sb.push_back('{0, 32'h0, 1'b0});
        @(negedge clk);
        checks++;
        if ({pselx, penable, pwrite, paddr, pwdata, pstrb, pprot} !== {1'b1, 1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF, 3'b010}) begin
            errors++;
            $display("FAIL wait_setup: psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h pstrb=%h pprot=%b", pselx, penable, pwrite, paddr, pwdata, pstrb, pprot);
        end
        drive_req(0, 32'hFFFF, 1'b0, 32'h0BAD0BAD, 4'h1, 3'b111);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 2) req[0] = 1'b0;
            checks++;
            if ({pselx, penable, pwrite, paddr, pwdata, pstrb, pprot, done} !== {1'b1, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF, 3'b010, 2'b00}) begin
                errors++;
                $display("FAIL wait_access c%0d: psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h pstrb=%h pprot=%b done=%b", c, pselx, penable, pwrite, paddr, pwdata, pstrb, pprot, done);
            end
            if (c == 4) pready = 1'b1;
        end
        @(negedge clk);
        pop_exp(e, ok);
        checks++;
        if (!ok || done !== N'(1 << e.idx) || rdata !== e.rdata || slverr !== e.slverr) begin
            errors++;
            $display("FAIL wait_done: done=%b rdata=%h slverr=%b want idx %0d rdata=%h slverr=%b", done, rdata, slverr, e.idx, e.rdata, e.slverr);
        end
        @(negedge clk);
    endtask

    task automatic run_timeout(input bit late_ready, input logic [31:0] rd);
        exp_t e;
        bit   ok;
        int   acc;
        int   n;
        pready = 1'b0; pslverr = 1'b0; prdata = rd;
        drive_req(0, 32'h50, 1'b0, 32'h0, 4'h0, 3'b000);
        req[0] = 1'b1;
        sb.push_back(late_ready ? '{0, rd, 1'b0} : '{0, 32'h0, 1'b1});
        acc = 0;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (done !== '0) break;
            if (penable === 1'b1) begin
                acc++;
                if (late_ready && acc == TO) pready = 1'b1;
            end
        end
        req[0] = 1'b0;
        pop_exp(e, ok);
        checks++;
        if (acc != TO) begin
            errors++;
            $display("FAIL timeout_len ready=%0d: access cycles=%0d want %0d", late_ready, acc, TO);
        end
        checks++;
        if (!ok || done !== N'(1 << e.idx) || rdata !== e.rdata || slverr !== e.slverr) begin
            errors++;
            $display("FAIL timeout_done ready=%0d: done=%b rdata=%h slverr=%b want idx %0d rdata=%h slverr=%b", late_ready, done, rdata, slverr, e.idx, e.rdata, e.slverr);
        end
        pready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_in_access();
        exp_t e;
        bit   ok;
        logic [N-1:0] d;
        int   n;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0BADCAFE;
        drive_req(0, 32'h40, 1'b0, 32'h0, 4'h0, 3'b000);
        drive_req(1, 32'h44, 1'b0, 32'h0, 4'h0, 3'b000);
        req = 2'b11;
        @(negedge clk);
        checks++;
        if (paddr !== 32'h44 || pselx !== 1'b1) begin
            errors++;
            $display("FAIL rst_rr_pick: paddr=%h psel=%b want 00000044 1", paddr, pselx);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({pselx, penable, busy, done} !== 5'b00000) begin
            errors++;
            $display("FAIL rst_abort: psel=%b pen=%b busy=%b done=%b want all 0", pselx, penable, busy, done);
        end
        pready = 1'b1;
        sb.push_back('{0, 32'h0BADCAFE, 1'b0});
        @(negedge clk);
        checks++;
        if (paddr !== 32'h40 || pselx !== 1'b1 || done !== '0) begin
            errors++;
            $display("FAIL rst_regrant: paddr=%h psel=%b done=%b want 00000040 1 00", paddr, pselx, done);
        end
        wait_done(10, d, n);
        req = 2'b00;
        pop_exp(e, ok);
        checks++;
        if (!ok || d !== N'(1 << e.idx) || rdata !== e.rdata || slverr !== e.slverr) begin
            errors++;
            $display("FAIL rst_after_done: done=%b rdata=%h slverr=%b want idx %0d rdata=%h slverr=%b", d, rdata, slverr, e.idx, e.rdata, e.slverr);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_slverr();
        test_contention();
        test_wait_states();
        run_timeout(1'b1, 32'h13579BDF);
        run_timeout(1'b0, 32'h55555555);
        test_reset_in_access();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
